// File: rtl/cache_write_buffer_if.sv
// cache_write_buffer_if: CPU write request side and
// way write strobe/ack side of the cache write buffer.
interface cache_write_buffer_if #(
  parameter int NUM_WAYS     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 4,
  parameter int DEPTH        = 4
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int CW       = $clog2(DEPTH + 1);

  logic                    req_valid;
  logic                    req_ready;
  logic [NUM_WAYS-1:0]     req_way;
  logic [OFFSET_WIDTH-1:0] req_offset;
  logic [DATA_WIDTH-1:0]   req_data;
  logic [BE_WIDTH-1:0]     req_be;
  logic [NUM_WAYS-1:0]     way_w_en;
  logic [OFFSET_WIDTH-1:0] way_offset;
  logic [DATA_WIDTH-1:0]   way_data;
  logic [BE_WIDTH-1:0]     way_be;
  logic [NUM_WAYS-1:0]     way_w_ack;
  logic                    wr_done;
  logic                    err_timeout;
  logic                    err_way;
  logic [CW-1:0]           count;
  logic                    idle;

  modport master (
    output req_valid, req_way, req_offset,
           req_data, req_be, way_w_ack,
    input  req_ready, way_w_en, way_offset,
           way_data, way_be, wr_done,
           err_timeout, err_way, count, idle
  );

  modport slave (
    input  req_valid, req_way, req_offset,
           req_data, req_be, way_w_ack,
    output req_ready, way_w_en, way_offset,
           way_data, way_be, wr_done,
           err_timeout, err_way, count, idle
  );
endinterface

// File: rtl/cache_write_buffer.sv
// cache_write_buffer: queued, coalescing write path from
// the cache control FSM to the data ways, with ack watchdog.
module cache_write_buffer #(
  parameter int NUM_WAYS     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 4,
  parameter int DEPTH        = 4,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cache_write_buffer_if.slave  bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = (ACK_TIMEOUT > 0) ?
                      $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  state_t                  r_state;
  logic [NUM_WAYS-1:0]     r_way  [DEPTH];
  logic [OFFSET_WIDTH-1:0] r_off  [DEPTH];
  logic [DATA_WIDTH-1:0]   r_data [DEPTH];
  logic [BE_WIDTH-1:0]     r_be   [DEPTH];
  logic [PW-1:0]           r_head;
  logic [PW-1:0]           r_tail;
  logic [CW-1:0]           r_count;
  logic [WW-1:0]           r_wd;
  logic                    r_wr_done;
  logic                    r_err_to;
  logic                    r_err_way;

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_way_ok;
  logic                    w_issue;
  logic [PW-1:0]           w_last;
  logic                    w_coalesce;
  logic                    w_push;
  logic                    w_ack;
  logic                    w_timeout;
  logic                    w_pop;
  logic [CW-1:0]           w_count_nxt;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign w_ready  = reset_n && (r_count < CW'(DEPTH));
  assign w_accept = bus.req_valid && w_ready;
  assign w_way_ok = (bus.req_way != '0) &&
    ((bus.req_way & (bus.req_way - 1'b1)) == '0);
  assign w_issue  = (r_state == S_ISSUE);
  assign w_last   = r_tail - 1'b1;

  // The head in ISSUE must stay frozen, so never merge into it.
  assign w_coalesce = w_accept && w_way_ok &&
    (r_count != '0) &&
    (r_way[w_last] == bus.req_way) &&
    (r_off[w_last] == bus.req_offset) &&
    !(w_issue && (r_count == CW'(1)));

  assign w_push = w_accept && w_way_ok && !w_coalesce;

  assign w_ack = w_issue &&
    (|(bus.way_w_ack & r_way[r_head]));

  assign w_timeout = (ACK_TIMEOUT != 0) && w_issue &&
    !w_ack && (r_wd == WW'(ACK_TIMEOUT - 1));

  assign w_pop = w_ack || w_timeout;

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Byte-lane merge of the new request into the tail entry.
  always_comb begin
    w_merged = r_data[w_last];
    for (int k = 0; k < BE_WIDTH; k++) begin
      if (bus.req_be[k]) begin
        w_merged[8*k +: 8] = bus.req_data[8*k +: 8];
      end
    end
  end

  // Entry storage: push writes the tail, coalesce merges it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_way[i]  <= '0;
        r_off[i]  <= '0;
        r_data[i] <= '0;
        r_be[i]   <= '0;
      end
    end else if (w_push) begin
      r_way[r_tail]  <= bus.req_way;
      r_off[r_tail]  <= bus.req_offset;
      r_data[r_tail] <= bus.req_data;
      r_be[r_tail]   <= bus.req_be;
    end else if (w_coalesce) begin
      r_data[w_last] <= w_merged;
      r_be[w_last]   <= r_be[w_last] | bus.req_be;
    end
  end

  // Ring pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  // Issue FSM with the per-entry ack watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_wd    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wd <= '0;
          if (r_count != '0) r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          unique case (1'b1)
            w_ack: begin
              r_wd    <= '0;
              r_state <= (w_count_nxt != '0) ?
                         S_ISSUE : S_IDLE;
            end
            w_timeout: begin
              r_wd    <= '0;
              r_state <= S_IDLE;
            end
            default: r_wd <= r_wd + 1'b1;
          endcase
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_done <= 1'b0;
      r_err_to  <= 1'b0;
      r_err_way <= 1'b0;
    end else begin
      r_wr_done <= w_ack;
      r_err_to  <= w_timeout;
      r_err_way <= w_accept && !w_way_ok;
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.way_w_en    = w_issue ? r_way[r_head]  : '0;
  assign bus.way_offset  = w_issue ? r_off[r_head]  : '0;
  assign bus.way_data    = w_issue ? r_data[r_head] : '0;
  assign bus.way_be      = w_issue ? r_be[r_head]   : '0;
  assign bus.wr_done     = r_wr_done;
  assign bus.err_timeout = r_err_to;
  assign bus.err_way     = r_err_way;
  assign bus.count       = r_count;
  assign bus.idle        = (r_count == '0) && !w_issue;
endmodule

// File: doc/cache_write_buffer.md
# cache_write_buffer

Parametrised write buffer between the cache control FSM and the cache data ways. It queues up to DEPTH CPU write requests with byte enables, merges a new write into the youngest queued entry when way and offset match, and issues writes to the one-hot-selected way one at a time under a w_en/w_ack handshake. A watchdog drops a write that goes unacknowledged for too long and flags it. It replaces the single-entry write path and removes the per-write stall on the control FSM.

## Interface
- NUM_WAYS, 4, number of cache ways; one-hot way select width
- DATA_WIDTH, 32, data bus width; multiple of 8
- OFFSET_WIDTH, 4, word offset within a line
- DEPTH, 4, queue entries; ≥2, power of two
- ACK_TIMEOUT, 15, max ISSUE cycles without ack before drop; 0 disables the watchdog
- BE_WIDTH, DATA_WIDTH/8, derived byte-enable width; not overridable
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  write request present
- req_ready  out  1  buffer can accept: reset_n && count < DEPTH
- req_way  in  NUM_WAYS  one-hot target way
- req_offset  in  OFFSET_WIDTH  word offset
- req_data  in  DATA_WIDTH  write data
- req_be  in  BE_WIDTH  byte enables; bit k covers data[8k+7:8k]
- way_w_en  out  NUM_WAYS  write strobe to a way; at most one bit set
- way_offset  out  OFFSET_WIDTH  head-entry offset; 0 when not issuing
- way_data  out  DATA_WIDTH  head-entry data; 0 when not issuing
- way_be  out  BE_WIDTH  head-entry byte enables; 0 when not issuing
- way_w_ack  in  NUM_WAYS  per-way write-complete
- wr_done  out  1  one-cycle pulse: a write retired by ack
- err_timeout  out  1  one-cycle pulse: a write dropped by the watchdog
- err_way  out  1  one-cycle pulse: request rejected for a non-one-hot req_way
- count  out  $clog2(DEPTH+1)  occupied entries
- idle  out  1  count == 0 and FSM in IDLE

## Operation
- Accept occurs on an edge where req_valid && req_ready.
- Invalid way: req_way zero or multi-hot is still accepted (handshake completes). It is not queued. err_way pulses the next cycle.
- Coalesce: the accepted request matches the tail entry's way and offset, count ≥ 1, and the tail is not the head currently in ISSUE.
  - Per byte k with req_be[k]=1, the tail byte is overwritten and tail be[k] is set. Other bytes are unchanged.
  - count is unchanged.
- Otherwise the request is pushed at the tail and count is incremented.
- FSM states:
  - IDLE: all way outputs are 0. Go to ISSUE when count > 0.
  - ISSUE: way_w_en = head way, with way_offset/data/be from the head entry. The watchdog counter increments each cycle.
- Ack: way_w_ack bit matching the head's way is sampled high.
  - Pop the head, pulse wr_done next cycle, clear the watchdog.
  - Stay in ISSUE if count after pop > 0, presenting the next entry back-to-back. Otherwise go to IDLE.
  - Acks from non-target ways are ignored.
- Timeout: watchdog reaches ACK_TIMEOUT with no ack. Pop the head, pulse err_timeout next cycle, clear the watchdog, go to IDLE.
- Ack and timeout on the same edge: the ack wins.
- Simultaneous push and pop: count is unchanged and the new entry is queued behind.
- A full buffer deasserts req_ready even when a pop happens on the same edge.

## Timing
- Reset (asynchronous, any time, including mid-ISSUE):
  - Queue empties, count=0, FSM goes to IDLE, watchdog clears.
  - All outputs become 0 except idle=1; req_ready=0 while reset_n is low and 1 after release.
  - An in-flight write is abandoned without wr_done or error.
- Accept to first way_w_en: 1 cycle. Accept at edge N into an empty, idle buffer gives way_w_en high after edge N+1.
- way_w_en and fields are held stable until the ack or timeout edge and deassert (or change to the next entry) right after that edge.
- Minimum 1 cycle per write when the way acks in the same cycle it is strobed.
- wr_done, err_timeout and err_way are each exactly one cycle wide and are registered.
- count and idle update on the same edge as the push or pop.
- Pointers wrap modulo DEPTH.

## Test plan
- Single write: way=0100, off=3, data=0xDEADBEEF, be=1111, ack after 2 cycles -> way_w_en=0100 for 3 cycles with fields held; wr_done once; count 1→0; idle=1.
- Fill: 5 distinct requests, no ack -> first 4 accepted, req_ready=0 at count=4; after one ack the 5th is accepted on the following edge; 5 writes retire in FIFO order.
- Coalesce: (way 0001, off 2, 0x000000AA, be 0001) with head busy, then same way/off 0x0000BB00 be 0010 -> single entry 0x0000BBAA be 0011; count stays 2.
- Timeout: ACK_TIMEOUT=15, no ack -> err_timeout pulse after 15 ISSUE cycles; entry dropped; next entry issued after one IDLE cycle.
- Invalid way: req_way=0011 -> accepted, err_way pulse, count unchanged, no way_w_en.
- Reset mid-ISSUE with 3 entries -> all outputs 0 immediately; count=0; no wr_done; normal single-write flow afterwards.
